// File: rtl/data_memory_ctrl_if.sv
// Request/response bus between the MEM stage and the data memory controller.
interface data_memory_ctrl_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              req_i;
  logic              we_i;
  logic [1:0]        size_i;
  logic              unsigned_i;
  logic [ADDR_W-1:0] addr_i;
  logic [31:0]       wdata_i;
  logic              ready_o;
  logic              rvalid_o;
  logic [31:0]       rdata_o;
  logic              err_o;

  modport master (
    output req_i, we_i, size_i, unsigned_i, addr_i, wdata_i,
    input  ready_o, rvalid_o, rdata_o, err_o
  );

  modport slave (
    input  req_i, we_i, size_i, unsigned_i, addr_i, wdata_i,
    output ready_o, rvalid_o, rdata_o, err_o
  );
endinterface

// File: rtl/data_memory_ctrl.sv
// Multi-cycle byte-addressed data memory with byte/half/word access,
// load extension, alignment/range checking and a req/ready/valid handshake.
module data_memory_ctrl #(
  parameter int unsigned DEPTH   = 256,
  parameter int unsigned LATENCY = 2,
  parameter int unsigned ADDR_W  = 32
) (
  input  logic               clk_i,
  input  logic               rst_i,
  data_memory_ctrl_if.slave  bus
);

  localparam int unsigned AW       = $clog2(DEPTH);
  localparam int unsigned CW       = 4;
  localparam int unsigned CNT_INIT = (LATENCY > 1) ? LATENCY - 2 : 0;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t            state;
  logic [CW-1:0]     cnt;
  logic              rvalid_q;
  logic [31:0]       rdata_q;
  logic              err_q;

  logic              we_q;
  logic [1:0]        size_q;
  logic              uns_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;

  logic [7:0]        mem [DEPTH];

  logic              ready_c;
  logic              accept_c;
  logic              commit_c;
  logic              c_we;
  logic [1:0]        c_size;
  logic              c_uns;
  logic [ADDR_W-1:0] c_addr;
  logic [31:0]       c_wdata;
  logic              c_err;
  logic [ADDR_W:0]   last_c;
  logic [1:0]        nb_m1_c;
  logic [AW-1:0]     idx0, idx1, idx2, idx3;
  logic [31:0]       load_c;

  assign ready_c  = rst_i && (state != WAIT);
  assign accept_c = bus.req_i && ready_c;

  // With LATENCY=1 the accept edge is also the commit edge, so use live inputs.
  assign commit_c = rst_i && ((accept_c && (LATENCY == 1)) ||
                              ((state == WAIT) && (cnt == '0)));

  assign c_we    = accept_c ? bus.we_i       : we_q;
  assign c_size  = accept_c ? bus.size_i     : size_q;
  assign c_uns   = accept_c ? bus.unsigned_i : uns_q;
  assign c_addr  = accept_c ? bus.addr_i     : addr_q;
  assign c_wdata = accept_c ? bus.wdata_i    : wdata_q;

  // Range check is done one bit wider than the address so it cannot wrap.
  always_comb begin
    nb_m1_c = 2'd0;
    case (c_size)
      2'd1:    nb_m1_c = 2'd1;
      2'd2:    nb_m1_c = 2'd3;
      default: nb_m1_c = 2'd0;
    endcase
    last_c = {1'b0, c_addr} + (ADDR_W+1)'(nb_m1_c);
    c_err  = 1'b0;
    if (c_size == 2'd3)                              c_err = 1'b1;
    if ((c_size == 2'd1) && c_addr[0])               c_err = 1'b1;
    if ((c_size == 2'd2) && (c_addr[1:0] != 2'b00))  c_err = 1'b1;
    if (last_c >= (ADDR_W+1)'(DEPTH))                c_err = 1'b1;
  end

  assign idx0 = c_addr[AW-1:0];
  assign idx1 = idx0 + AW'(1);
  assign idx2 = idx0 + AW'(2);
  assign idx3 = idx0 + AW'(3);

  // Little-endian load assembly with optional sign extension.
  always_comb begin
    load_c = 32'd0;
    case (c_size)
      2'd0:    load_c = c_uns ? {24'd0, mem[idx0]}
                              : {{24{mem[idx0][7]}}, mem[idx0]};
      2'd1:    load_c = c_uns ? {16'd0, mem[idx1], mem[idx0]}
                              : {{16{mem[idx1][7]}}, mem[idx1], mem[idx0]};
      default: load_c = {mem[idx3], mem[idx2], mem[idx1], mem[idx0]};
    endcase
  end

  // Storage is not reset; only the addressed bytes of a legal store change.
  always_ff @(posedge clk_i) begin
    if (commit_c && c_we && !c_err) begin
      mem[idx0] <= c_wdata[7:0];
      if (c_size != 2'd0) mem[idx1] <= c_wdata[15:8];
      if (c_size == 2'd2) begin
        mem[idx2] <= c_wdata[23:16];
        mem[idx3] <= c_wdata[31:24];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (accept_c) begin
      we_q    <= bus.we_i;
      size_q  <= bus.size_i;
      uns_q   <= bus.unsigned_i;
      addr_q  <= bus.addr_i;
      wdata_q <= bus.wdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state    <= IDLE;
      cnt      <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= 32'd0;
      err_q    <= 1'b0;
    end else begin
      rvalid_q <= 1'b0;
      case (state)
        IDLE, RESP: begin
          if (accept_c) begin
            if (LATENCY == 1) begin
              state <= RESP;
            end else begin
              state <= WAIT;
              cnt   <= CW'(CNT_INIT);
            end
          end else begin
            state <= IDLE;
          end
        end
        WAIT: begin
          if (cnt == '0) state <= RESP;
          else           cnt   <= cnt - CW'(1);
        end
        default: state <= IDLE;
      endcase
      if (commit_c) begin
        rvalid_q <= 1'b1;
        err_q    <= c_err;
        rdata_q  <= (c_we || c_err) ? 32'd0 : load_c;
      end
    end
  end

  assign bus.ready_o  = ready_c;
  assign bus.rvalid_o = rvalid_q;
  assign bus.rdata_o  = rdata_q;
  assign bus.err_o    = err_q;

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Scoreboard bench: three controllers with LATENCY 2, 1 and 3 on one clock.
module tb_data_memory_ctrl;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst1, rst2, rst3;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  exp_t q1[$], q2[$], q3[$];

  data_memory_ctrl_if #(.ADDR_W(32)) b1 ();
  data_memory_ctrl_if #(.ADDR_W(32)) b2 ();
  data_memory_ctrl_if #(.ADDR_W(32)) b3 ();

  data_memory_ctrl #(.DEPTH(256), .LATENCY(2), .ADDR_W(32)) u_lat2 (.clk_i(clk), .rst_i(rst1), .bus(b1));
  data_memory_ctrl #(.DEPTH(256), .LATENCY(1), .ADDR_W(32)) u_lat1 (.clk_i(clk), .rst_i(rst2), .bus(b2));
  data_memory_ctrl #(.DEPTH(256), .LATENCY(3), .ADDR_W(32)) u_lat3 (.clk_i(clk), .rst_i(rst3), .bus(b3));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int lat_of(input int sel);
    return (sel == 1) ? 2 : (sel == 2) ? 1 : 3;
  endfunction

  function automatic logic rdy(input int sel);
    case (sel)
      1:       return b1.ready_o;
      2:       return b2.ready_o;
      default: return b3.ready_o;
    endcase
  endfunction

  task automatic drive(input int sel, input logic req, input logic we, input logic [1:0] sz,
                       input logic uns, input logic [31:0] addr, input logic [31:0] wd);
    case (sel)
      1: begin b1.req_i = req; b1.we_i = we; b1.size_i = sz; b1.unsigned_i = uns; b1.addr_i = addr; b1.wdata_i = wd; end
      2: begin b2.req_i = req; b2.we_i = we; b2.size_i = sz; b2.unsigned_i = uns; b2.addr_i = addr; b2.wdata_i = wd; end
      default: begin b3.req_i = req; b3.we_i = we; b3.size_i = sz; b3.unsigned_i = uns; b3.addr_i = addr; b3.wdata_i = wd; end
    endcase
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic issue(input int sel, input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] exp_d, input logic exp_e, input bit track);
    exp_t e;
    bit   done = 0;
    drive(sel, 1'b1, we, sz, uns, addr, wd);
    for (int i = 0; i < 20 && !done; i++) begin
      #1;
      if (rdy(sel)) begin
        e.rdata = exp_d;
        e.err   = exp_e;
        e.cyc   = cyc + 1 + lat_of(sel) - 1;
        if (track) begin
          case (sel)
            1:       q1.push_back(e);
            2:       q2.push_back(e);
            default: q3.push_back(e);
          endcase
        end
        done = 1;
      end
      @(posedge clk);
      @(negedge clk);
    end
    if (!done) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle(input int sel);
    drive(sel, 1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0);
  endtask

  task automatic drain();
    for (int i = 0; i < 50 && (q1.size() + q2.size() + q3.size()) != 0; i++) @(negedge clk);
    chk("drain", 32'(q1.size() + q2.size() + q3.size()), 32'd0);
  endtask

  task automatic retire(input int sel, input logic [31:0] d, input logic e);
    exp_t x;
    int   n;
    n = (sel == 1) ? q1.size() : (sel == 2) ? q2.size() : q3.size();
    if (n == 0) begin
      chk($sformatf("spurious_rvalid%0d", sel), 32'd1, 32'd0);
    end else begin
      case (sel)
        1:       x = q1.pop_front();
        2:       x = q2.pop_front();
        default: x = q3.pop_front();
      endcase
      chk($sformatf("rdata%0d", sel), d, x.rdata);
      chk($sformatf("err%0d", sel), 32'(e), 32'(x.err));
      chk($sformatf("resp_cycle%0d", sel), 32'(cyc), 32'(x.cyc));
    end
  endtask

  always @(negedge clk) begin
    if (b1.rvalid_o === 1'b1) retire(1, b1.rdata_o, b1.err_o);
    if (b2.rvalid_o === 1'b1) retire(2, b2.rdata_o, b2.err_o);
    if (b3.rvalid_o === 1'b1) retire(3, b3.rdata_o, b3.err_o);
  end

  initial begin
    rst1 = 1'b0; rst2 = 1'b0; rst3 = 1'b0;
    idle(1); idle(2); idle(3);
    #1;
    chk("rst_ready1", 32'(b1.ready_o), 32'd0);
    repeat (2) @(negedge clk);
    chk("rst_ready_held", 32'(b1.ready_o), 32'd0);
    rst1 = 1'b1; rst2 = 1'b1; rst3 = 1'b1;
    #1;
    chk("post_rst_ready", 32'(b1.ready_o), 32'd1);
    chk("post_rst_rvalid", 32'(b1.rvalid_o), 32'd0);
    chk("post_rst_rdata", b1.rdata_o, 32'd0);
    @(negedge clk);

    // LATENCY=2: data path, extension, partial stores, errors.
    issue(1, 1, 2'd2, 0, 32'h10, 32'hDEADBEEF, 32'h0, 0, 1);
    issue(1, 0, 2'd2, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0, 1);
    issue(1, 0, 2'd0, 1, 32'h10, 32'h0, 32'h000000EF, 0, 1);
    issue(1, 0, 2'd0, 0, 32'h13, 32'h0, 32'hFFFFFFDE, 0, 1);
    issue(1, 0, 2'd1, 1, 32'h12, 32'h0, 32'h0000DEAD, 0, 1);
    issue(1, 0, 2'd1, 0, 32'h12, 32'h0, 32'hFFFFDEAD, 0, 1);
    issue(1, 1, 2'd0, 0, 32'h11, 32'hAAAAAA55, 32'h0, 0, 1);
    issue(1, 0, 2'd2, 1, 32'h10, 32'h0, 32'hDEAD55EF, 0, 1);
    issue(1, 0, 2'd2, 0, 32'h12, 32'h0, 32'h0, 1, 1);
    issue(1, 1, 2'd2, 0, 32'hFC, 32'h11223344, 32'h0, 0, 1);
    issue(1, 1, 2'd2, 0, 32'hFE, 32'h99999999, 32'h0, 1, 1);
    issue(1, 0, 2'd2, 0, 32'hFC, 32'h0, 32'h11223344, 0, 1);
    issue(1, 0, 2'd3, 0, 32'h10, 32'h0, 32'h0, 1, 1);
    issue(1, 1, 2'd3, 0, 32'h10, 32'h77777777, 32'h0, 1, 1);
    issue(1, 0, 2'd2, 0, 32'h10, 32'h0, 32'hDEAD55EF, 0, 1);
    issue(1, 0, 2'd2, 0, 32'hFFFFFFFC, 32'h0, 32'h0, 1, 1);
    issue(1, 1, 2'd2, 0, 32'h100, 32'h12345678, 32'h0, 1, 1);
    issue(1, 0, 2'd0, 1, 32'hFF, 32'h0, 32'h00000011, 0, 1);
    issue(1, 0, 2'd1, 1, 32'hFE, 32'h0, 32'h00001122, 0, 1);
    issue(1, 0, 2'd1, 1, 32'hFF, 32'h0, 32'h0, 1, 1);
    issue(1, 0, 2'd0, 1, 32'h100, 32'h0, 32'h0, 1, 1);
    idle(1);
    drain();

    // LATENCY=1: req held high across four back-to-back requests.
    issue(2, 1, 2'd2, 0, 32'h40, 32'hCAFEF00D, 32'h0, 0, 1);
    issue(2, 1, 2'd0, 0, 32'h44, 32'h00000080, 32'h0, 0, 1);
    issue(2, 0, 2'd2, 0, 32'h40, 32'h0, 32'hCAFEF00D, 0, 1);
    issue(2, 0, 2'd0, 0, 32'h44, 32'h0, 32'hFFFFFF80, 0, 1);
    idle(2);
    drain();

    // LATENCY=3: reset one cycle after accepting a store aborts it.
    issue(3, 1, 2'd2, 0, 32'h20, 32'h0BADF00D, 32'h0, 0, 1);
    issue(3, 0, 2'd2, 0, 32'h20, 32'h0, 32'h0BADF00D, 0, 1);
    idle(3);
    drain();
    issue(3, 1, 2'd2, 0, 32'h20, 32'h12345678, 32'h0, 0, 0);
    idle(3);
    rst3 = 1'b0;
    #1;
    chk("rst_ready3", 32'(b3.ready_o), 32'd0);
    @(negedge clk);
    rst3 = 1'b1;
    repeat (5) @(negedge clk);
    issue(3, 0, 2'd2, 0, 32'h20, 32'h0, 32'h0BADF00D, 0, 1);
    idle(3);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
